uart_rx: RTL

//  Asynchronous serial receiver; the receiving end of the uart_tx frame format.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_shift_in_register.sv | 24 ++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and receiver state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_t;

endpackage

// File: rtl/uart_rx_shift_in_register.sv
// Serial-in, parallel-out shift register; bits enter at the MSB end so an
// LSB-first stream ends up in natural bit order after Width shifts.
module shift_in_register #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             enable,
  output logic [Width-1:0] parallel_out
);

  // Shift one bit in from the top whenever enable is high.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this register is reset because the received word is observable
    // through data_out; plain storage arrays would normally be left unreset.
    if (rst) begin
      parallel_out <= '0;
    end else if (enable) begin
      parallel_out <= {serial_in, parallel_out[Width-1:1]};
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the RX line, finds the start edge, samples each
// bit mid-period and delivers the word with parity/framing flags as a pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int Parity       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  output logic                parity_error,
  output logic                framing_error,
  output logic                busy
);

  if (ClockDivider < 4) begin : g_bad_divider
    $error("uart_rx: ClockDivider must be >= 4");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_rx: DataBits must be in [5,9]");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("uart_rx: StopBits must be 1 or 2");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_parity
    $error("uart_rx: Parity must be 0, 1 or 2");
  end

  localparam int      CntW       = $clog2(ClockDivider);
  localparam int      BitW       = 4;
  localparam parity_t ParityMode = parity_t'(Parity[1:0]);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClockDivider - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClockDivider / 2 - 1);

  rx_state_t         state, state_next;
  logic              rx_meta, rx_s, rx_prev;
  logic [CntW-1:0]   cnt;
  logic [BitW-1:0]   bit_cnt;
  logic [DataBits-1:0] sr_data;
  logic              perr, ferr;
  logic              fall, tick, half_tick;
  logic              frame_start, cnt_clr, bit_clr, bit_inc;
  logic              shift_en, parity_smp, stop_smp, done;

  // Two-flop synchronizer plus the previous-sample register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= in_bit;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign tick      = (cnt == LastCnt);
  assign half_tick = (cnt == HalfCnt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    shift_en    = 1'b0;
    parity_smp  = 1'b0;
    stop_smp    = 1'b0;
    done        = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          frame_start = 1'b1;
          cnt_clr     = 1'b1;
          state_next  = RX_START;
        end
      end
      RX_START: begin
        if (half_tick) begin
          if (rx_s) begin
            state_next = RX_IDLE;
          end else begin
            cnt_clr    = 1'b1;
            bit_clr    = 1'b1;
            state_next = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == BitW'(DataBits - 1)) begin
            bit_clr    = 1'b1;
            state_next = (ParityMode != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          parity_smp = 1'b1;
          state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          stop_smp = 1'b1;
          if (bit_cnt == BitW'(StopBits - 1)) begin
            done = 1'b1;
            // A low line here is a break or stuck line: wait for it to rise
            // so the low level is not mistaken for a new start bit.
            state_next = rx_s ? RX_IDLE : RX_BREAK_WAIT;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      RX_BREAK_WAIT: begin
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  // Bit-period counter and bit index within the current field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      if (cnt_clr || state == RX_IDLE || state == RX_BREAK_WAIT) cnt <= '0;
      else if (tick)                                            cnt <= '0;
      else                                                      cnt <= cnt + 1'b1;
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  shift_in_register #(.Width(DataBits)) u_shift (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (rx_s),
    .enable       (shift_en),
    .parallel_out (sr_data)
  );

  // Per-frame error accumulation, cleared at each detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else if (frame_start) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (parity_smp) begin
        if (ParityMode == PARITY_ODD) perr <= (rx_s != ~^sr_data);
        else                          perr <= (rx_s != ^sr_data);
      end
      if (stop_smp && !rx_s) ferr <= 1'b1;
    end
  end

  // Output register: word and flags update together with the valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      data_out_valid <= done;
      if (done) begin
        data_out      <= sr_data;
        parity_error  <= perr;
        framing_error <= ferr | ~rx_s;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule
